// File: rtl/shift_arbiter_pkg.sv
// Shared widths, shifter opcodes and buffer states
// for the two-requester shift arbiter.
package shift_arbiter_pkg;

   localparam int N = 16;
   localparam int C = 4;

   localparam logic [1:0] OP_ROTL = 2'b00;
   localparam logic [1:0] OP_SHL  = 2'b01;
   localparam logic [1:0] OP_ROTR = 2'b10;
   localparam logic [1:0] OP_SRL  = 2'b11;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/barrelShifter.sv
// Combinational 16-bit barrel shifter core:
// rotate/shift left/right by Cnt, or full bit-reverse.
module barrelShifter
   import shift_arbiter_pkg::*;
(
   input  logic [N-1:0] In,
   input  logic [C-1:0] Cnt,
   input  logic [1:0]   Op,
   input  logic         BTR,
   output logic [N-1:0] Out
);

   logic [C:0]   inv;
   logic [N-1:0] rev;

   // Cnt=0 gives inv=N, so the wrap-around term shifts out to zero
   assign inv = (C+1)'(N) - {1'b0, Cnt};

   always_comb begin
      for (int i = 0; i < N; i++) begin
         rev[i] = In[N-1-i];
      end
   end

   always_comb begin
      Out = '0;
      if (BTR) begin
         Out = rev;
      end else begin
         unique case (Op)
            OP_ROTL: Out = (In << Cnt) | (In >> inv);
            OP_SHL:  Out = In << Cnt;
            OP_ROTR: Out = (In >> Cnt) | (In << inv);
            OP_SRL:  Out = In >> Cnt;
         endcase
      end
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two
// requesters, with a one-entry tagged result buffer.
module shift_arbiter
   import shift_arbiter_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_in,
   input  logic [C-1:0] req0_cnt,
   input  logic [1:0]   req0_op,
   input  logic         req0_btr,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_in,
   input  logic [C-1:0] req1_cnt,
   input  logic [1:0]   req1_op,
   input  logic         req1_btr,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_out,
   output logic         rsp_id
);

   state_e       state_q, state_d;
   logic [N-1:0] out_q, out_d;
   logic         id_q, id_d;
   logic         rr_q, rr_d;

   logic         gnt0, gnt1;
   logic         can_accept, accept;
   logic [N-1:0] sh_in, sh_out;
   logic [C-1:0] sh_cnt;
   logic [1:0]   sh_op;
   logic         sh_btr;

   // On a tie the requester that did not win last time goes
   assign gnt0 = req0_valid & (~req1_valid | rr_q);
   assign gnt1 = req1_valid & (~req0_valid | ~rr_q);

   assign can_accept = (state_q == ST_EMPTY) | (rsp_valid & rsp_ready);
   assign accept     = (gnt0 | gnt1) & can_accept & ~rst;

   assign sh_in  = gnt1 ? req1_in  : req0_in;
   assign sh_cnt = gnt1 ? req1_cnt : req0_cnt;
   assign sh_op  = gnt1 ? req1_op  : req0_op;
   assign sh_btr = gnt1 ? req1_btr : req0_btr;

   barrelShifter u_core (
      .In  (sh_in),
      .Cnt (sh_cnt),
      .Op  (sh_op),
      .BTR (sh_btr),
      .Out (sh_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         out_q   <= '0;
         id_q    <= 1'b0;
         rr_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = ST_FULL;
      end else if (rsp_valid & rsp_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_comb begin
      rsp_valid  = (state_q == ST_FULL);
      req0_ready = gnt0 & can_accept & ~rst;
      req1_ready = gnt1 & can_accept & ~rst;
   end

   assign out_d = accept ? sh_out : out_q;
   assign id_d  = accept ? gnt1   : id_q;
   assign rr_d  = accept ? gnt1   : rr_q;

   assign rsp_out = out_q;
   assign rsp_id  = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios
// plus a randomized soak against a queue-based reference model.
module tb_shift_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_btr;
   logic [15:0] req0_in;
   logic [3:0]  req0_cnt;
   logic [1:0]  req0_op;
   logic        req1_valid, req1_ready, req1_btr;
   logic [15:0] req1_in;
   logic [3:0]  req1_cnt;
   logic [1:0]  req1_op;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [15:0] rsp_out;

   int checks = 0;
   int errors = 0;

   shift_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_in    (req0_in),
      .req0_cnt   (req0_cnt),
      .req0_op    (req0_op),
      .req0_btr   (req0_btr),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_in    (req1_in),
      .req1_cnt   (req1_cnt),
      .req1_op    (req1_op),
      .req1_btr   (req1_btr),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_out    (rsp_out),
      .rsp_id     (rsp_id)
   );

   always #5 clk = ~clk;

   // Reference shifter from plain integer arithmetic
   function automatic logic [15:0] ref_shift(logic [15:0] x, int k, int op, bit btr);
      int unsigned v, r;
      v = x;
      r = 0;
      if (btr) begin
         for (int i = 0; i < 16; i++) r = r | (((v >> i) & 1) << (15 - i));
      end else begin
         case (op)
            0: r = ((v << k) | (v >> (16 - k))) & 32'hFFFF;
            1: r = (v << k) & 32'hFFFF;
            2: r = ((v >> k) | (v << (16 - k))) & 32'hFFFF;
            default: r = v >> k;
         endcase
      end
      return r[15:0];
   endfunction

   task automatic idle();
      req0_valid = 0; req0_in = '0; req0_cnt = '0; req0_op = '0; req0_btr = 0;
      req1_valid = 0; req1_in = '0; req1_cnt = '0; req1_op = '0; req1_btr = 0;
      rsp_ready = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      idle();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
      checks++;
      if (rsp_out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h exp 0000", rsp_out); end
      checks++;
      if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %b exp 0", rsp_id); end
   endtask

   task automatic test_single();
      @(negedge clk);
      req0_valid = 1; req0_in = 16'h8001; req0_cnt = 4'd1; req0_op = 2'b00; req0_btr = 0;
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", req0_ready); end
      @(negedge clk);
      req0_valid = 0;
      #1;
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
      checks++;
      if (rsp_out !== 16'h0003) begin errors++; $display("FAIL single_out got %h exp 0003", rsp_out); end
      checks++;
      if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id got %b exp 0", rsp_id); end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", rsp_valid); end
      checks++;
      if (rsp_out !== 16'h0003) begin errors++; $display("FAIL drain_keep got %h exp 0003", rsp_out); end
   endtask

   task automatic test_ops();
      logic [15:0] exp_t [5];
      exp_t = '{16'h0F3A, 16'h0F30, 16'h3A0F, 16'h0A0F, 16'hCF05};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req1_valid = 1; req1_in = 16'hA0F3; req1_cnt = 4'd4;
         req1_op = 2'(i % 4); req1_btr = (i == 4);
         rsp_ready = 1;
         @(negedge clk);
         req1_valid = 0;
         #1;
         checks++;
         if (rsp_out !== exp_t[i]) begin errors++; $display("FAIL op%0d_out got %h exp %h", i, rsp_out, exp_t[i]); end
         checks++;
         if (rsp_id !== 1'b1) begin errors++; $display("FAIL op%0d_id got %b exp 1", i, rsp_id); end
      end
      @(negedge clk);
      rsp_ready = 0;
   endtask

   task automatic test_contention();
      do_reset();
      req0_valid = 1; req0_in = 16'h0001; req0_cnt = 4'd1; req0_op = 2'b01;
      req1_valid = 1; req1_in = 16'h0001; req1_cnt = 4'd2; req1_op = 2'b01;
      rsp_ready = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (req0_ready !== (k % 2 == 0)) begin errors++; $display("FAIL cont%0d_r0 got %b exp %b", k, req0_ready, k % 2 == 0); end
         checks++;
         if (req1_ready !== (k % 2 == 1)) begin errors++; $display("FAIL cont%0d_r1 got %b exp %b", k, req1_ready, k % 2 == 1); end
         if (k > 0) begin
            checks++;
            if (rsp_id !== 1'((k - 1) % 2)) begin errors++; $display("FAIL cont%0d_id got %b exp %0d", k, rsp_id, (k - 1) % 2); end
            checks++;
            if (rsp_out !== (((k - 1) % 2 == 0) ? 16'h0002 : 16'h0004)) begin
               errors++; $display("FAIL cont%0d_out got %h", k, rsp_out);
            end
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (rsp_id !== 1'b1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL cont_last got id %b v %b exp 1 1", rsp_id, rsp_valid); end
      idle();
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      req0_valid = 1; req0_in = 16'h1234; req0_cnt = 4'd0; req0_op = 2'b00;
      rsp_ready = 0;
      @(negedge clk);
      req0_in = 16'h00F0; req0_cnt = 4'd4; req0_op = 2'b01;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (rsp_out !== 16'h1234 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL bp%0d_hold got %h v %b exp 1234 1", k, rsp_out, rsp_valid);
         end
         checks++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL bp%0d_ready got %b%b exp 00", k, req0_ready, req1_ready);
         end
         @(negedge clk);
      end
      rsp_ready = 1;
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got %b exp 1", req0_ready); end
      @(negedge clk);
      req0_valid = 0;
      rsp_ready = 0;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_out !== 16'h0F00) begin
         errors++; $display("FAIL bp_reload got %h v %b exp 0f00 1", rsp_out, rsp_valid);
      end
   endtask

   task automatic test_reset_full();
      @(negedge clk);
      rst = 1;
      req0_valid = 1; req0_in = 16'h0001; req0_cnt = 4'd3; req0_op = 2'b01;
      #1;
      checks++;
      if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_pend_ready got %b exp 0", req0_ready); end
      @(negedge clk);
      rst = 0;
      req0_valid = 0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_out !== 16'h0000) begin
         errors++; $display("FAIL rst_full got %h v %b exp 0000 0", rsp_out, rsp_valid);
      end
      req0_valid = 1;
      req1_valid = 1;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         errors++; $display("FAIL rst_tie got %b%b exp 10", req0_ready, req1_ready);
      end
      @(negedge clk);
      idle();
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
   endtask

   task automatic test_soak();
      logic [16:0] q[$];
      bit rr = 1;
      bit a0 = 0;
      bit a1 = 0;
      bit exp_rv, can, any, win, er0, er1;
      do_reset();
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(negedge clk);
         if (!req0_valid || a0) begin
            req0_valid = ($urandom % 3) != 0;
            req0_in = 16'($urandom); req0_cnt = 4'($urandom);
            req0_op = 2'($urandom); req0_btr = ($urandom % 8) == 0;
         end
         if (!req1_valid || a1) begin
            req1_valid = ($urandom % 3) != 0;
            req1_in = 16'($urandom); req1_cnt = 4'($urandom);
            req1_op = 2'($urandom); req1_btr = ($urandom % 8) == 0;
         end
         rsp_ready = ($urandom % 4) != 0;
         #1;
         exp_rv = q.size() != 0;
         checks++;
         if (rsp_valid !== exp_rv) begin errors++; $display("FAIL soak%0d_valid got %b exp %b", cyc, rsp_valid, exp_rv); end
         if (exp_rv) begin
            checks++;
            if ({rsp_id, rsp_out} !== q[0]) begin
               errors++; $display("FAIL soak%0d_rsp got %b/%h exp %b/%h", cyc, rsp_id, rsp_out, q[0][16], q[0][15:0]);
            end
         end
         can = !exp_rv || rsp_ready;
         any = req0_valid || req1_valid;
         win = (req0_valid && req1_valid) ? !rr : !req0_valid;
         er0 = can && any && !win;
         er1 = can && any && win;
         checks++;
         if (req0_ready !== er0 || req1_ready !== er1) begin
            errors++; $display("FAIL soak%0d_ready got %b%b exp %b%b", cyc, req0_ready, req1_ready, er0, er1);
         end
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         if (exp_rv && rsp_ready) void'(q.pop_front());
         if (a0) begin q.push_back({1'b0, ref_shift(req0_in, req0_cnt, req0_op, req0_btr)}); rr = 0; end
         if (a1) begin q.push_back({1'b1, ref_shift(req1_in, req1_cnt, req1_op, req1_btr)}); rr = 1; end
      end
      @(negedge clk);
      idle();
   endtask

   initial begin
      rst = 1;
      idle();
      test_reset();
      test_single();
      test_ops();
      test_contention();
      test_backpressure();
      test_reset_full();
      test_soak();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
